// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and byte/FIFO sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_t;

    localparam int UART_BYTE_W        = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module uart_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = $clog2(N)'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO push port between NUM_REQ
// byte streams; a grant is held for a whole message.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FIFO_DEPTH   = UART_TX_FIFO_DEPTH,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [4:0]                     tx_fifo_count,
    output logic                           tx_fifo_push,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t             state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          gnt_idx_q, gnt_idx_d;
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic [7:0]             idle_cnt_q, idle_cnt_d;
    logic                   push_q, push_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;
    logic [5:0]             fifo_fill;
    logic                   room_ok;
    logic                   in_xfer;
    logic                   xfer_fire;
    logic [UART_BYTE_W-1:0] data_arr [NUM_REQ];

    uart_rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // A push already in flight counts against FIFO room, so the FIFO never overflows.
    assign fifo_fill = {1'b0, tx_fifo_count} + {5'b0, push_q};
    assign room_ok   = fifo_fill < 6'(FIFO_DEPTH);
    assign in_xfer   = (state_q == XFER);
    assign xfer_fire = in_xfer && req_valid[gnt_idx_q] && room_ok;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign data_arr[gi]  = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
            assign grant[gi]     = in_xfer && (gnt_idx_q == PW'(gi));
            assign req_ready[gi] = in_xfer && (gnt_idx_q == PW'(gi)) && room_ok;
        end
    endgenerate

    assign tx_fifo_push = push_q;
    assign tx_data      = tx_data_q;
    assign busy         = (state_q != IDLE);

    // Next-state: arbitration, message transfer, burst limit and idle timeout.
    always_comb begin
        logic release_grant;
        release_grant = 1'b0;
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_idx_d     = gnt_idx_q;
        burst_cnt_d   = burst_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        push_d        = 1'b0;
        tx_data_d     = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_idx_d = pick_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                burst_cnt_d = '0;
                idle_cnt_d  = '0;
                state_d     = XFER;
            end
            XFER: begin
                if (xfer_fire) begin
                    // A transfer always takes precedence over the idle timeout.
                    push_d      = 1'b1;
                    tx_data_d   = data_arr[gnt_idx_q];
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    idle_cnt_d  = '0;
                    if (req_last[gnt_idx_q] || (burst_cnt_d == BW'(MAX_BURST)))
                        release_grant = 1'b1;
                end else if (!req_valid[gnt_idx_q]) begin
                    // Stalled-by-FIFO cycles are not idle; only missing data counts.
                    idle_cnt_d = idle_cnt_q + 8'd1;
                    if (idle_cnt_d == 8'(IDLE_TIMEOUT))
                        release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_idx_q == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset also drops any pending push.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            push_q      <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            push_q      <= push_d;
            tx_data_q   <= tx_data_d;
        end
    end

endmodule
